// File: rtl/jk_pkg.sv
// Shared JK flip-flop code points and the toggle-form excitation helper.
package jk_pkg;

    // {J,K} codes, J is the MSB.
    localparam logic [1:0] JK_HOLD   = 2'd0;
    localparam logic [1:0] JK_RESET  = 2'd1;
    localparam logic [1:0] JK_SET    = 2'd2;
    localparam logic [1:0] JK_TOGGLE = 2'd3;

    // Toggle form: a bit that must change gets TOGGLE, a bit that stays gets HOLD.
    function automatic logic [1:0] jk_toggle_code(input logic q, input logic nxt);
        logic [1:0] code;
        if (q ^ nxt) begin
            code = JK_TOGGLE;
        end else begin
            code = JK_HOLD;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and status bundle of the modulo-N JK counter.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrap
    );
endinterface

// File: rtl/jk_mod_counter_jk_ff.sv
// Single JK flip-flop with synchronous active-high reset.
module JK_ff
    import jk_pkg::*;
(
    input  logic clock,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    // JK state update: reset dominates, otherwise the {J,K} code selects the action.
    always_ff @(posedge clock) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: combinational next-state and J/K excitation
// feeding one JK_ff per bit, plus a registered wrap pulse.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic           clock,
    input  logic           rst,
    jk_mod_counter_if.slave bus
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS out of range 2..2**WIDTH");
    end

    // Arithmetic is one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_EXT_C = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_EXT_C = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_EXT_C = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ZERO_EXT_C = {(WIDTH+1){1'b0}};

    logic [WIDTH-1:0]      q_s;
    logic [WIDTH-1:0]      qb_s;
    logic [WIDTH:0]        count_ext_s;
    logic [WIDTH:0]        load_ext_s;
    logic [WIDTH:0]        next_ext_s;
    logic [WIDTH-1:0]      next_s;
    logic                  at_max_s;
    logic                  at_zero_s;
    logic                  tc_s;
    logic                  wrap_next_s;
    logic [WIDTH-1:0][1:0] jk_s;
    logic                  wrap_r;

    // Next count: load (saturating) over enabled up/down step over hold.
    always_comb begin
        count_ext_s = {1'b0, q_s};
        load_ext_s  = {1'b0, bus.load_val};
        at_max_s    = (count_ext_s == MAX_EXT_C);
        at_zero_s   = (count_ext_s == ZERO_EXT_C);
        next_ext_s  = count_ext_s;
        if (bus.load) begin
            if (load_ext_s < MOD_EXT_C) begin
                next_ext_s = load_ext_s;
            end else begin
                next_ext_s = MAX_EXT_C;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max_s) begin
                    next_ext_s = ZERO_EXT_C;
                end else begin
                    next_ext_s = count_ext_s + ONE_EXT_C;
                end
            end else begin
                if (at_zero_s) begin
                    next_ext_s = MAX_EXT_C;
                end else begin
                    next_ext_s = count_ext_s - ONE_EXT_C;
                end
            end
        end else begin
            next_ext_s = count_ext_s;
        end
        next_s      = next_ext_s[WIDTH-1:0];
        tc_s        = bus.en & ((bus.up & at_max_s) | (~bus.up & at_zero_s));
        wrap_next_s = tc_s & ~bus.load;
    end

    // Per-bit excitation in toggle form: only HOLD or TOGGLE are ever issued.
    always_comb begin
        jk_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            jk_s[i] = jk_toggle_code(q_s[i], next_s[i]);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        JK_ff u_ff (
            .clock (clock),
            .rst   (rst),
            .j     (jk_s[g][1]),
            .k     (jk_s[g][0]),
            .q     (q_s[g]),
            .qb    (qb_s[g])
        );
    end

    // Wrap pulse: set on an enabled wrapping edge, cleared by reset or load.
    always_ff @(posedge clock) begin
        if (rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_next_s;
        end
    end

    assign bus.count = q_s;
    assign bus.tc    = tc_s;
    assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: directed steps push expected post-edge state, monitors compare.
module tb_jk_mod_counter;

    typedef struct {
        logic [3:0] count;
        logic       wrap;
        logic       tc;
        string      name;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    jk_mod_counter_if #(.WIDTH(4)) bus_a ();
    jk_mod_counter_if #(.WIDTH(4)) bus_b ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_a.slave)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_b.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus on the selected counter and record its expected state after the edge.
    task automatic step(input bit sel, input logic r, input logic e, input logic u,
                        input logic l, input logic [3:0] lv, input logic [3:0] ec,
                        input logic ew, input logic et, input string nm);
        exp_t x;
        @(negedge clock);
        rst = r;
        if (sel == 1'b0) begin
            bus_a.en = e; bus_a.up = u; bus_a.load = l; bus_a.load_val = lv;
            bus_b.en = 1'b0; bus_b.up = 1'b0; bus_b.load = 1'b0; bus_b.load_val = 4'd0;
        end else begin
            bus_b.en = e; bus_b.up = u; bus_b.load = l; bus_b.load_val = lv;
            bus_a.en = 1'b0; bus_a.up = 1'b0; bus_a.load = 1'b0; bus_a.load_val = 4'd0;
        end
        x.count = ec; x.wrap = ew; x.tc = et; x.name = nm;
        if (sel == 1'b0) q_a.push_back(x);
        else             q_b.push_back(x);
    endtask

    // Monitor for the MODULUS=10 counter.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (q_a.size() > 0) begin
                x = q_a.pop_front();
                chk({x.name, "_a_count"}, {4'd0, bus_a.count}, {4'd0, x.count});
                chk({x.name, "_a_wrap"},  {7'd0, bus_a.wrap},  {7'd0, x.wrap});
                chk({x.name, "_a_tc"},    {7'd0, bus_a.tc},    {7'd0, x.tc});
            end
        end
    end

    // Monitor for the full-range MODULUS=16 counter.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (q_b.size() > 0) begin
                x = q_b.pop_front();
                chk({x.name, "_b_count"}, {4'd0, bus_b.count}, {4'd0, x.count});
                chk({x.name, "_b_wrap"},  {7'd0, bus_b.wrap},  {7'd0, x.wrap});
                chk({x.name, "_b_tc"},    {7'd0, bus_b.tc},    {7'd0, x.tc});
            end
        end
    end

    initial begin
        bus_a.en = 1'b1; bus_a.up = 1'b1; bus_a.load = 1'b1; bus_a.load_val = 4'd7;
        bus_b.en = 1'b0; bus_b.up = 1'b0; bus_b.load = 1'b0; bus_b.load_val = 4'd0;

        // Reset dominates load/en; then counting starts on the first enabled edge.
        step(0, 1, 1, 1, 1, 4'd7,  4'd0, 0, 0, "rst0");
        step(0, 1, 1, 1, 1, 4'd7,  4'd0, 0, 0, "rst1");
        step(0, 0, 1, 1, 0, 4'd0,  4'd1, 0, 0, "rel1");
        step(0, 0, 1, 1, 0, 4'd0,  4'd2, 0, 0, "rel2");
        step(0, 0, 1, 1, 0, 4'd0,  4'd3, 0, 0, "rel3");
        // Up wrap 8 -> 9 -> 0 -> 1.
        step(0, 0, 0, 1, 1, 4'd8,  4'd8, 0, 0, "ld8");
        step(0, 0, 1, 1, 0, 4'd0,  4'd9, 0, 1, "up9");
        step(0, 0, 1, 1, 0, 4'd0,  4'd0, 1, 0, "up0");
        step(0, 0, 1, 1, 0, 4'd0,  4'd1, 0, 0, "up1");
        // Down wrap 1 -> 0 -> 9 -> 8.
        step(0, 0, 0, 0, 1, 4'd1,  4'd1, 0, 0, "ld1");
        step(0, 0, 1, 0, 0, 4'd0,  4'd0, 0, 1, "dn0");
        step(0, 0, 1, 0, 0, 4'd0,  4'd9, 1, 0, "dn9");
        step(0, 0, 1, 0, 0, 4'd0,  4'd8, 0, 0, "dn8");
        // Load saturation and load winning over a wrap edge.
        step(0, 0, 0, 0, 1, 4'd13, 4'd9, 0, 0, "sat13");
        step(0, 0, 0, 0, 1, 4'd5,  4'd5, 0, 0, "ld5");
        step(0, 0, 1, 1, 1, 4'd9,  4'd9, 0, 1, "ld9en");
        step(0, 0, 1, 1, 1, 4'd3,  4'd3, 0, 0, "ldwrap");
        // Excitation: 7 -> 8 toggles every bit; hold issues HOLD everywhere.
        step(0, 0, 0, 1, 1, 4'd6,  4'd6, 0, 0, "ld6");
        step(0, 0, 1, 1, 0, 4'd0,  4'd7, 0, 0, "up7");
        @(posedge clock); #2;
        chk("jk_all_toggle", dut_a.jk_s, 8'hFF);
        step(0, 0, 1, 1, 0, 4'd0,  4'd8, 0, 0, "up8");
        step(0, 0, 0, 1, 0, 4'd0,  4'd8, 0, 0, "hold8");
        @(posedge clock); #2;
        chk("jk_all_hold", dut_a.jk_s, 8'h00);
        // Direction change with no dead cycle.
        step(0, 0, 1, 0, 0, 4'd0,  4'd7, 0, 0, "dir_dn");
        step(0, 0, 1, 1, 0, 4'd0,  4'd8, 0, 0, "dir_up");
        // Reset overriding a wrap edge, then normal counting.
        step(0, 0, 0, 1, 1, 4'd9,  4'd9, 0, 0, "ld9");
        step(0, 1, 1, 1, 0, 4'd0,  4'd0, 0, 0, "rstwrap");
        step(0, 0, 1, 1, 0, 4'd0,  4'd1, 0, 0, "after_rst");

        // Full-range counter: 15 -> 0 up and 0 -> 15 down both wrap.
        step(1, 0, 0, 1, 1, 4'd14, 4'd14, 0, 0, "b_ld14");
        step(1, 0, 1, 1, 0, 4'd0,  4'd15, 0, 1, "b_up15");
        step(1, 0, 1, 1, 0, 4'd0,  4'd0,  1, 0, "b_up0");
        step(1, 0, 1, 0, 0, 4'd0,  4'd15, 1, 0, "b_dn15");
        step(1, 0, 1, 0, 0, 4'd0,  4'd14, 0, 0, "b_dn14");

        @(negedge clock);
        bus_b.en = 1'b0;
        for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
            @(posedge clock);
        end
        #5;
        chk("scoreboard_drained", 8'(q_a.size() + q_b.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter built from `JK_ff` cells. It computes per-bit J/K excitation from the current count and the requested next count, and drives one `JK_ff` per bit. It sits directly upstream of the flip-flop stage as its excitation generator. It is the standard counter used by the lab sequencing and timer blocks.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MODULUS`, default 10: count range is 0 .. MODULUS-1.
  - Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
  - An illegal value is an elaboration error.

- `clock` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement. Sampled only when `en`=1.
- `load` input 1: synchronous parallel load.
- `load_val` input WIDTH: value to load.
- `count` output WIDTH: current count, taken from the `JK_ff` Q outputs.
- `tc` output 1: terminal count, combinational. Equals `en & ((up & count==MODULUS-1) | (~up & count==0))`.
- `wrap` output 1: registered one-cycle pulse. High in the cycle after an edge on which the count wrapped.

## Operation
- Priority per edge: `rst` > `load` > `en` > hold.
- **rst**
  - All `JK_ff` cells get `rst` directly, so `count`=0.
  - `wrap`=0.
  - `load`, `en` and `up` are ignored.
- **load**
  - next = `load_val` if `load_val` < MODULUS, else MODULUS-1 (saturate).
  - `wrap`=0.
  - Ignores `en`.
- **en, up=1**
  - next = count+1, except MODULUS-1 → 0.
  - The wrap transition registers `wrap`=1.
- **en, up=0**
  - next = count-1, except 0 → MODULUS-1.
  - The wrap transition registers `wrap`=1.
- **hold** (`en`=0, no load): next = count, `wrap`=0.
- **Excitation** (toggle form): for each bit i, t_i = count[i] ^ next[i], and J_i = K_i = t_i.
  - Held bits use the JK HOLD code (00).
  - Changed bits use TOGGLE (11).
  - SET/RESET codes are never issued in normal operation.
- **Arithmetic**
  - Next-state arithmetic is done at WIDTH+1 bits before the modulus compare.
  - With MODULUS = 2^WIDTH, the wrap compare still decodes MODULUS-1 explicitly, never by carry-out alone.
- **Qb** outputs of `JK_ff` are unused.

## Timing
- Latency: `count` updates on the edge where the controlling input is sampled. It is visible one cycle after `en`/`load` is asserted.
- `tc` is combinational from `count`, `en` and `up`. It is high during the cycle before the wrapping edge.
- `wrap` is registered alongside `count`. It is high in the first cycle showing the wrapped value and lasts exactly one cycle unless wrapping repeats (e.g. MODULUS=2 counting continuously).
- **Reset mid-count**: on the `rst` edge `count`→0 and `wrap`→0, overriding a simultaneous wrap.
- **Simultaneous `load` and wrap condition**: the load wins and `wrap` stays 0.
- **Direction change**: takes effect on the next enabled edge with no dead cycle.
- **After reset release**: the first enabled edge counts normally.

## Structure
- Shared package `jk_pkg` holds:
  - JK code constants HOLD=2'd0, RESET=2'd1, SET=2'd2, TOGGLE=2'd3 (J is the MSB).
  - The toggle-form helper function mapping (q, next) to {J,K}.
- Sub-module: `JK_ff`, instantiated WIDTH times in a generate loop. The counter contains no other state except the `wrap` register.
- Next-state and excitation logic is purely combinational in the top module.

## Test plan
- **Reset**: `rst`=1 for 2 cycles with `en`=1, `load`=1, `load_val`=7 → `count`=0 and `wrap`=0. After release with `en`=1, `up`=1, the count goes 1, 2, 3.
- **Up wrap** (MODULUS=10): load 8, then `en`=1, `up`=1 for 3 cycles → `count` 9, 0, 1. `tc`=1 while `count`=9. `wrap`=1 only in the cycle `count`=0.
- **Down wrap**: load 1, then `en`=1, `up`=0 → `count` 0, 9, 8. `tc`=1 while `count`=0. `wrap`=1 in the cycle `count`=9.
- **Load saturation**: `load_val`=13 → `count`=9. `load_val`=5 → `count`=5. Load asserted on a wrap edge (`count`=9, `en`=1, `up`=1, `load_val`=3) → `count`=3, `wrap`=0.
- **Excitation check**: probe J/K at `count`=7 going up → bits [3:0] receive TOGGLE, TOGGLE, TOGGLE, TOGGLE, giving 8. At `en`=0 every cell receives HOLD and `count` is unchanged.
- **Full-range config** (WIDTH=4, MODULUS=16): `en`=1, `up`=1 from 15 → 0 with `wrap`=1. With `up`=0 from 0 → 15 with `wrap`=1.
